// File: rtl/qcl_debounce_pkg.sv
// qcl_debounce_pkg: shared scan-state type and counter sizing helper for the debounce scanner.
// Rev 1.0
`default_nettype none

package qcl_debounce_pkg;

  typedef enum logic [0:0] {
    eIdle = 1'b0,
    eScan = 1'b1
  } scan_state_e;

  // Counter must hold values up to stable_ticks inclusive for the compare.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/qcl_rr_arb.sv
// qcl_rr_arb: round-robin arbiter with grant lock and rotating priority pointer.
// Rev 1.0
`default_nettype none

module qcl_rr_arb #(
  parameter  int els_p = 4,
  localparam int IW    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [els_p-1:0] i_req,
  input  logic             i_lock,
  input  logic             i_advance,
  output logic [els_p-1:0] o_grant_oh,
  output logic [IW-1:0]    o_grant_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_lock_idx;
  logic          r_lock_v;
  logic [IW-1:0] w_rr_idx;
  logic [IW-1:0] w_grant_idx;
  logic          w_found;
  int            w_cand;

  always_comb begin
    w_rr_idx = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    for (int off = 0; off < els_p; off++) begin
      w_cand = (int'(r_ptr) + off) % els_p;
      if (!w_found && i_req[IW'(w_cand)]) begin
        w_found  = 1'b1;
        w_rr_idx = IW'(w_cand);
      end
    end
  end

  // A presented but unaccepted grant is frozen so the consumer sees stable outputs.
  assign w_grant_idx = r_lock_v ? r_lock_idx : w_rr_idx;

  always_comb begin
    o_grant_oh              = '0;
    o_grant_oh[w_grant_idx] = |i_req;
  end

  assign o_grant_idx = w_grant_idx;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr      <= '0;
      r_lock_v   <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock_v <= i_lock;
      if (i_lock) r_lock_idx <= w_grant_idx;
      if (i_advance) r_ptr <= (w_grant_idx == IW'(els_p - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/qcl_debounce_scan.sv
// qcl_debounce_scan: time-multiplexed debounce of els_p inputs with a valid/ready event port.
// Rev 1.0
`default_nettype none

module qcl_debounce_scan
  import qcl_debounce_pkg::*;
#(
  parameter  int els_p          = 4,
  parameter  int tick_lg_p      = 16,
  parameter  int stable_ticks_p = 20,
  localparam int IW             = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [els_p-1:0] i,
  output logic [els_p-1:0] o,
  output logic             evt_v_o,
  output logic [IW-1:0]    evt_id_o,
  output logic             evt_level_o,
  input  logic             evt_ready_i,
  output logic             overrun_o
);

  localparam int CW = cnt_width(stable_ticks_p);

  logic [els_p-1:0]     r_sync1;
  logic [els_p-1:0]     r_sync2;
  logic [tick_lg_p-1:0] r_presc;
  scan_state_e          r_state;
  scan_state_e          w_state_nxt;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        w_ptr_nxt;
  logic [CW-1:0]        r_cnt [els_p];
  logic [els_p-1:0]     r_o;
  logic [els_p-1:0]     r_pend;
  logic                 r_overrun;

  logic                 w_tick;
  logic                 w_proc;
  logic                 w_sync_k;
  logic                 w_o_k;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_flip;
  logic [els_p-1:0]     w_set_oh;
  logic [els_p-1:0]     w_clr_oh;
  logic [els_p-1:0]     w_grant_oh;
  logic [IW-1:0]        w_grant_idx;
  logic                 w_xfer;
  logic                 w_lock;

  assign w_tick = &r_presc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eIdle;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      eIdle: begin
        if (w_tick) begin
          w_state_nxt = eScan;
          w_ptr_nxt   = '0;
        end
      end
      eScan: begin
        if (r_ptr == IW'(els_p - 1)) w_state_nxt = eIdle;
        else                         w_ptr_nxt   = r_ptr + 1'b1;
      end
    endcase
  end

  // Only the channel under the scan pointer is evaluated each cycle.
  always_comb begin
    w_proc    = (r_state == eScan);
    w_sync_k  = r_sync2[r_ptr];
    w_o_k     = r_o[r_ptr];
    w_cnt_inc = r_cnt[r_ptr] + 1'b1;
    w_flip    = w_proc && (w_sync_k != w_o_k) && (w_cnt_inc == CW'(stable_ticks_p));
    w_set_oh  = '0;
    if (w_flip) w_set_oh[r_ptr] = 1'b1;
  end

  assign evt_v_o  = |r_pend;
  assign w_xfer   = evt_v_o & evt_ready_i;
  assign w_lock   = evt_v_o & ~evt_ready_i;
  assign w_clr_oh = w_grant_oh & {els_p{w_xfer}};

  qcl_rr_arb #(
    .els_p (els_p)
  ) u_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .i_req       (r_pend),
    .i_lock      (w_lock),
    .i_advance   (w_xfer),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_presc   <= '0;
      r_o       <= '0;
      r_pend    <= '0;
      r_overrun <= 1'b0;
      for (int k = 0; k < els_p; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= i;
      r_sync2 <= r_sync1;
      r_presc <= r_presc + 1'b1;
      // A new flip on the channel being accepted wins over the clear.
      r_pend  <= (r_pend & ~w_clr_oh) | w_set_oh;
      if (w_flip && r_pend[r_ptr] && !w_clr_oh[r_ptr]) r_overrun <= 1'b1;
      if (w_proc) begin
        if (w_sync_k == w_o_k) begin
          r_cnt[r_ptr] <= '0;
        end else if (w_flip) begin
          r_o[r_ptr]   <= ~w_o_k;
          r_cnt[r_ptr] <= '0;
        end else begin
          r_cnt[r_ptr] <= w_cnt_inc;
        end
      end
    end
  end

  assign o           = r_o;
  assign overrun_o   = r_overrun;
  assign evt_id_o    = w_grant_idx;
  assign evt_level_o = r_o[w_grant_idx];

endmodule

`default_nettype wire

// File: tb/tb_qcl_debounce_scan.sv
// tb_qcl_debounce_scan: directed scenarios plus random stimulus against a cycle-level reference model.
// Rev 1.0
`default_nettype none

module tb_qcl_debounce_scan;

  localparam int EL = 4;
  localparam int TL = 3;
  localparam int ST = 3;
  localparam int PERIOD = 1 << TL;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] in_r;
  logic [3:0] o;
  logic       evt_v;
  logic [1:0] evt_id;
  logic       evt_level;
  logic       ready;
  logic       overrun;

  always #5 clk = ~clk;

  qcl_debounce_scan #(
    .els_p          (EL),
    .tick_lg_p      (TL),
    .stable_ticks_p (ST)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .i           (in_r),
    .o           (o),
    .evt_v_o     (evt_v),
    .evt_id_o    (evt_id),
    .evt_level_o (evt_level),
    .evt_ready_i (ready),
    .overrun_o   (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle index since reset, raw input history, per-channel state.
  int         cyc;
  logic [3:0] m_hist [$];
  bit         m_o    [EL];
  bit         m_pend [EL];
  int         m_cnt  [EL];
  bit         m_ovr;
  int         m_rrptr;
  int         m_lock;

  logic [3:0] cur;
  bit         seen_v;
  bit         seen_o0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] m_ovec();
    logic [3:0] v;
    for (int k = 0; k < EL; k++) v[k] = m_o[k];
    return v;
  endfunction

  function automatic bit m_valid();
    bit v = 1'b0;
    for (int k = 0; k < EL; k++) v |= m_pend[k];
    return v;
  endfunction

  function automatic int m_grant();
    if (m_lock >= 0) return m_lock;
    for (int off = 0; off < EL; off++) begin
      int k;
      k = (m_rrptr + off) % EL;
      if (m_pend[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_clear();
    cyc = 0;
    m_hist.delete();
    for (int k = 0; k < EL; k++) begin
      m_o[k] = 1'b0; m_pend[k] = 1'b0; m_cnt[k] = 0;
    end
    m_ovr   = 1'b0;
    m_rrptr = 0;
    m_lock  = -1;
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
  task automatic do_reset();
    reset_i = 1'b1;
    ready   = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_clear();
  endtask

  task automatic step(input logic [3:0] iv, input logic rdy);
    int         g;
    int         flip;
    bit         v;
    bit         xfer;
    logic [3:0] sync;
    in_r  = iv;
    ready = rdy;
    #1;
    g = m_grant();
    v = m_valid();
    chk("o", 32'(o), 32'(m_ovec()));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("evt_v", 32'(evt_v), 32'(v));
    if (v) begin
      chk("evt_id", 32'(evt_id), 32'(g));
      chk("evt_level", 32'(evt_level), 32'(m_o[g]));
    end
    m_hist.push_back(iv);
    xfer = v && rdy;
    sync = (cyc >= 2) ? m_hist[cyc-2] : 4'b0;
    flip = -1;
    for (int k = 0; k < EL; k++) begin
      // Channel k is visited k+1 cycles after each tick; ticks fall on cycles PERIOD-1 mod PERIOD.
      if (cyc - 1 - k >= 0 && ((cyc - 1 - k) % PERIOD) == PERIOD - 1) begin
        if (sync[k] == m_o[k]) begin
          m_cnt[k] = 0;
        end else if (m_cnt[k] + 1 == ST) begin
          if (m_pend[k] && !(xfer && g == k)) m_ovr = 1'b1;
          m_o[k]   = ~m_o[k];
          m_cnt[k] = 0;
          flip     = k;
        end else begin
          m_cnt[k]++;
        end
      end
    end
    if (xfer) begin
      m_pend[g] = 1'b0;
      m_rrptr   = (g + 1) % EL;
    end
    if (flip >= 0) m_pend[flip] = 1'b1;
    m_lock = (v && !rdy) ? g : -1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    in_r    = '0;
    ready   = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_v", 32'(evt_v), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);

    // Single stable edge on channel 2.
    while (cyc < 40) begin
      step(4'b0100, cyc == 30);
      if (cyc == 26) chk("s1_o2_early", 32'(o[2]), 32'h0);
      if (cyc == 27) begin
        chk("s1_o2", 32'(o[2]), 32'h1);
        chk("s1_v", 32'(evt_v), 32'h1);
        chk("s1_id", 32'(evt_id), 32'h2);
        chk("s1_lvl", 32'(evt_level), 32'h1);
      end
      if (cyc == 31) chk("s1_drained", 32'(evt_v), 32'h0);
    end

    // Bounce rejection on channel 0.
    do_reset();
    seen_v  = 1'b0;
    seen_o0 = 1'b0;
    while (cyc < 100) begin
      step((cyc < 60) ? 4'(((cyc / 5) % 2)) : 4'b0, 1'($urandom_range(0, 1)));
      seen_v  |= evt_v;
      seen_o0 |= o[0];
    end
    chk("s2_no_evt", 32'(seen_v), 32'h0);
    chk("s2_o0_low", 32'(seen_o0), 32'h0);

    // Round-robin with backpressure.
    do_reset();
    while (cyc < 50) begin
      step(4'hF, cyc >= 40);
      if (cyc == 40) chk("s3_hold0", 32'(evt_id), 32'h0);
      if (cyc >= 40 && cyc <= 43) begin
        chk("s3_v", 32'(evt_v), 32'h1);
        chk("s3_order", 32'(evt_id), 32'(cyc - 40));
      end
      if (cyc == 44) chk("s3_empty", 32'(evt_v), 32'h0);
    end

    // Overrun on channel 1.
    do_reset();
    while (cyc < 60) begin
      step((cyc < 27) ? 4'b0010 : 4'b0000, 1'b0);
      if (cyc == 49) chk("s4_ovr_early", 32'(overrun), 32'h0);
    end
    chk("s4_ovr", 32'(overrun), 32'h1);
    chk("s4_v", 32'(evt_v), 32'h1);
    chk("s4_id", 32'(evt_id), 32'h1);
    chk("s4_lvl", 32'(evt_level), 32'h0);

    // Channel 3 flips in the cycle its earlier event is accepted.
    do_reset();
    while (cyc < 60) begin
      step((cyc < 28) ? 4'b1000 : 4'b0000, cyc == 51);
      if (cyc == 52) begin
        chk("s5_v", 32'(evt_v), 32'h1);
        chk("s5_id", 32'(evt_id), 32'h3);
        chk("s5_lvl", 32'(evt_level), 32'h0);
        chk("s5_ovr", 32'(overrun), 32'h0);
      end
    end

    // Reset during a scan with events pending.
    do_reset();
    while (cyc < 33) step(4'hF, 1'b0);
    in_r = 4'hF;
    do_reset();
    chk("s6_o", 32'(o), 32'h0);
    chk("s6_v", 32'(evt_v), 32'h0);
    chk("s6_ovr", 32'(overrun), 32'h0);
    while (cyc < 30) step(4'hF, 1'b1);

    // Random inputs and backpressure.
    for (int run = 0; run < 3; run++) begin
      do_reset();
      cur = 4'($urandom);
      for (int n = 0; n < 600; n++) begin
        for (int k = 0; k < EL; k++)
          if ($urandom_range(0, 31) == 0) cur[k] = ~cur[k];
        if ($urandom_range(0, 399) == 0) begin
          in_r = cur;
          do_reset();
        end
        step(cur, ($urandom_range(0, 3) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
